// File: rtl/axis_hdr_pkg.sv
// Shared constants for the header/payload packet arbiter: FSM encoding,
// completed-packet counter width and a small wrap helper.
package axis_hdr_pkg;

  localparam int STATE_WD = 2;

  localparam logic [STATE_WD-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_WD-1:0] ST_HDR  = 2'd1;
  localparam logic [STATE_WD-1:0] ST_PAY  = 2'd2;

  localparam int PKT_CNT_WD = 16;

  function automatic int wrap_inc(input int val, input int modulus);
    return (val + 1 >= modulus) ? 0 : val + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping,
// returned both one-hot and as an index.
module rr_pick #(
  parameter int N     = 2,
  parameter int ID_WD = 1
) (
  input  logic [N-1:0]     req,
  input  logic [ID_WD-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [ID_WD-1:0] gnt_id,
  output logic             any
);

  always_comb begin
    gnt_oh = '0;
    gnt_id = '0;
    any    = 1'b0;
    // offset k walks outward from ptr; j is the candidate it lands on
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!any && req[j] && (j == (int'(ptr) + k) % N)) begin
          any       = 1'b1;
          gnt_oh[j] = 1'b1;
          gnt_id    = ID_WD'(j);
        end
      end
    end
  end

endmodule

// File: rtl/axis_hdr_pkt_arbiter.sv
// Grants one requester at a time the inserter's header channel and then its
// payload channel until the last beat; round-robin between packets.
//   state | meaning
//   IDLE  | no owner; pick next header requester from rr_ptr
//   HDR   | owner's header routed to inserter until handshake
//   PAY   | owner's payload routed to inserter until last handshake
module axis_hdr_pkt_arbiter
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_REQ      = 2,
  parameter int ID_WD        = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic [NUM_REQ-1:0]              s_valid_in,
  input  logic [NUM_REQ*DATA_WD-1:0]      s_data_in,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0] s_keep_in,
  input  logic [NUM_REQ-1:0]              s_last_in,
  output logic [NUM_REQ-1:0]              s_ready_in,

  input  logic [NUM_REQ-1:0]              s_valid_insert,
  input  logic [NUM_REQ*DATA_WD-1:0]      s_data_insert,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0] s_keep_insert,
  input  logic [NUM_REQ*BYTE_CNT_WD-1:0]  s_byte_insert_cnt,
  output logic [NUM_REQ-1:0]              s_ready_insert,

  output logic                            valid_in,
  output logic [DATA_WD-1:0]              data_in,
  output logic [DATA_BYTE_WD-1:0]         keep_in,
  output logic                            last_in,
  input  logic                            ready_in,

  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
  input  logic                            ready_insert,

  output logic [ID_WD-1:0]                grant_id,
  output logic                            busy,
  output logic [PKT_CNT_WD-1:0]           pkt_cnt
);

  logic [STATE_WD-1:0] state_q;
  logic [ID_WD-1:0]    rr_ptr;
  logic [NUM_REQ-1:0]  pick_oh_unused;
  logic [ID_WD-1:0]    pick_id;
  logic                pick_any;
  logic                hdr_fire;
  logic                pay_done;

  rr_pick #(
    .N     (NUM_REQ),
    .ID_WD (ID_WD)
  ) u_rr_pick (
    .req    (s_valid_insert),
    .ptr    (rr_ptr),
    .gnt_oh (pick_oh_unused),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // Data fields follow the owner in every state; only valids/readies are gated.
  always_comb begin
    valid_insert    = 1'b0;
    data_insert     = '0;
    keep_insert     = '0;
    byte_insert_cnt = '0;
    valid_in        = 1'b0;
    data_in         = '0;
    keep_in         = '0;
    last_in         = 1'b0;
    s_ready_insert  = '0;
    s_ready_in      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WD'(i)) begin
        data_insert     = s_data_insert[i*DATA_WD +: DATA_WD];
        keep_insert     = s_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        byte_insert_cnt = s_byte_insert_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
        data_in         = s_data_in[i*DATA_WD +: DATA_WD];
        keep_in         = s_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        last_in         = s_last_in[i];
        if (state_q == ST_HDR) begin
          valid_insert      = s_valid_insert[i];
          s_ready_insert[i] = ready_insert;
        end
        if (state_q == ST_PAY) begin
          valid_in      = s_valid_in[i];
          s_ready_in[i] = ready_in;
        end
      end
    end
  end

  assign hdr_fire = valid_insert & ready_insert;
  assign pay_done = valid_in & ready_in & last_in;
  assign busy     = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      pkt_cnt  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_id <= pick_id;
            state_q  <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (hdr_fire) state_q <= ST_PAY;
        end
        ST_PAY: begin
          if (pay_done) begin
            state_q <= ST_IDLE;
            rr_ptr  <= ID_WD'(wrap_inc(int'(grant_id), NUM_REQ));
            pkt_cnt <= pkt_cnt + PKT_CNT_WD'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axis_hdr_pkt_arbiter.md
AXIS_HDR_PKT_ARBITER -- requirements
Module: axis_hdr_pkt_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WD, default 32, beat width; DATA_BYTE_WD, default DATA_WD/8, keep width; BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), header byte-count width; NUM_REQ, default 2, requester count (2..4); ID_WD, default $clog2(NUM_REQ), grant id width.
REQ-002 Ports SHALL be: clk, in, 1, sole clock; rst, in, 1, synchronous active-high reset.
REQ-003 Ports SHALL be: s_valid_in, in, NUM_REQ, per-requester payload valid; s_data_in, in, NUM_REQ*DATA_WD, payload data (requester i at slice i); s_keep_in, in, NUM_REQ*DATA_BYTE_WD, payload keep; s_last_in, in, NUM_REQ, payload last; s_ready_in, out, NUM_REQ, payload ready.
REQ-004 Ports SHALL be: s_valid_insert, in, NUM_REQ, header valid; s_data_insert, in, NUM_REQ*DATA_WD, header data; s_keep_insert, in, NUM_REQ*DATA_BYTE_WD, header keep; s_byte_insert_cnt, in, NUM_REQ*BYTE_CNT_WD, header byte count; s_ready_insert, out, NUM_REQ, header ready.
REQ-005 Ports SHALL be: valid_in/data_in/keep_in/last_in, out, 1/DATA_WD/DATA_BYTE_WD/1, payload to inserter; ready_in, in, 1, inserter payload ready.
REQ-006 Ports SHALL be: valid_insert/data_insert/keep_insert/byte_insert_cnt, out, 1/DATA_WD/DATA_BYTE_WD/BYTE_CNT_WD, header to inserter; ready_insert, in, 1, inserter header ready.
REQ-007 Ports SHALL be: grant_id, out, ID_WD, current owner; busy, out, 1, high when not IDLE; pkt_cnt, out, 16, completed packets.

Function
REQ-008 FSM SHALL have states IDLE, HDR, PAY, registered; grant_id and rr_ptr registered.
REQ-009 IDLE: requester i eligible iff s_valid_insert[i]; if any eligible, select first eligible at or after rr_ptr (wrapping), load grant_id, go HDR next cycle; else stay IDLE.
REQ-010 Arbitration latency SHALL be exactly 1 cycle from eligible header valid to valid_insert high.
REQ-011 HDR: header outputs SHALL combinationally mirror requester grant_id; s_ready_insert[grant_id]=ready_insert; on valid_insert&ready_insert go PAY.
REQ-012 PAY: payload outputs SHALL mirror requester grant_id; s_ready_in[grant_id]=ready_in; on valid_in&ready_in&last_in go IDLE, rr_ptr<=grant_id+1 mod NUM_REQ, pkt_cnt+1.
REQ-013 Non-granted requesters SHALL see ready 0 on both channels in every state; granted requester sees payload ready 0 in HDR and header ready 0 in PAY.
REQ-014 valid_insert SHALL be 0 outside HDR; valid_in SHALL be 0 outside PAY; data/keep/last/byte_cnt outputs don't-care when matching valid is 0.
REQ-015 Grant SHALL NOT change mid-packet, even if the owner deasserts valid or other requesters wait.
REQ-016 Payload valid of a requester SHALL be ignored unless it holds grant in PAY; a requester's second header while in PAY waits for next arbitration.
REQ-017 Single-beat packet (last on first payload beat) SHALL return to IDLE after one PAY handshake.
REQ-018 pkt_cnt SHALL wrap 0xFFFF->0x0000; rr_ptr wraps NUM_REQ-1->0.
REQ-019 One idle cycle SHALL separate packets (IDLE visited between every PAY and next HDR).

Reset
REQ-020 rst SHALL force state IDLE, grant_id 0, rr_ptr 0, pkt_cnt 0, busy 0, all valid and ready outputs 0 at next edge.
REQ-021 rst mid-packet SHALL abandon the packet without pkt_cnt increment; arbitration restarts from rr_ptr 0.

Structure
REQ-022 State encoding and pkt_cnt width SHALL live in shared package axis_hdr_pkg.
REQ-023 Round-robin selector SHALL be sub-module rr_pick (request vector, pointer -> one-hot/id, any).

Verification
REQ-024 Req0 only, header 0xA5A5A5A5 cnt 2, payload 3 beats last on beat 3, ready always 1 -> valid_insert 1 cycle after header valid, PAY 3 beats, pkt_cnt=1, busy low after.
REQ-025 Req0 and req1 headers together from reset -> req0 packet, IDLE cycle, req1 packet, grant_id 0 then 1, rr_ptr=0 after.
REQ-026 Req1 valid throughout req0's PAY -> s_ready_in[1]=0 and s_ready_insert[1]=0 until req0 last handshake.
REQ-027 ready_in toggling 1/0 in PAY for 4-beat packet -> beats forwarded only on ready high, data order preserved, state PAY throughout.
REQ-028 rst asserted during PAY beat 2 -> next cycle all outputs 0, state IDLE, pkt_cnt unchanged at prior value 0.
REQ-029 pkt_cnt preloaded path: 65536 single-beat packets -> pkt_cnt reads 0x0000.
